// File: rtl/stack_req_arbiter.sv
// stack_req_arbiter
// Two-requester round-robin arbiter and sequencer for a small stack/queue
// datapath. It tracks the stack occupancy so that only commands that can
// neither overflow nor underflow the stack are granted. It issues one stack
// command per grant and routes pop data back to the requester that asked.
//
// Cycle view of one transaction (E = the edge where valid&&ready is sampled):
//   IDLE     : reqN_ready is high for the winner; transfer happens at E.
//   ISSUE    : stk_valid/stk_ctl/stk_din are driven (registered at E).
//              occ updates at the end of this cycle.
//   POP_WAIT : pop only. The stack's registered stk_dout now holds the popped
//              word. reqN_rvalid pulses, and reqN_rdata shows that word.

module stack_req_arbiter #(
    parameter int  DEPTH = 3,
    parameter int  DW    = 16,
    localparam int OW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          req0_valid,
    input  logic [1:0]    req0_op,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    output logic          req0_rvalid,
    output logic [DW-1:0] req0_rdata,

    input  logic          req1_valid,
    input  logic [1:0]    req1_op,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic          req1_rvalid,
    output logic [DW-1:0] req1_rdata,

    output logic          stk_valid,
    output logic [1:0]    stk_ctl,
    output logic [DW-1:0] stk_din,
    input  logic [DW-1:0] stk_dout,
    input  logic          stk_wait,

    output logic [OW-1:0] occ,
    output logic          full,
    output logic          empty,
    output logic          ovf_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        POP_WAIT = 2'd2
    } state_t;

    // Command encoding shared by the requesters and the stack.
    localparam logic [1:0] OP_POP       = 2'b00;
    localparam logic [1:0] OP_PUSH_BYTE = 2'b01;
    localparam logic [1:0] OP_PUSH_WORD = 2'b10;
    localparam logic [1:0] OP_PUSH_PAIR = 2'b11;

    state_t        state;
    logic          last_grant;   // id of the most recent winner
    logic          id_q;         // owner of the command in flight
    logic [DW-1:0] rdata0_q;     // last pop word delivered to requester 0
    logic [DW-1:0] rdata1_q;     // last pop word delivered to requester 1

    logic          elig0;
    logic          elig1;
    logic          grant0;
    logic          grant1;
    logic [OW-1:0] occ_issue;    // occupancy after the command in ISSUE

    // A command is eligible when it fits in the registered occupancy:
    // pops need an entry, single pushes need one free slot, pair pushes two.
    function automatic logic op_eligible(input logic [1:0] op, input logic [OW-1:0] cnt);
        logic ok;
        case (op)
            OP_POP:       ok = (cnt != '0);
            OP_PUSH_PAIR: ok = (int'(cnt) <= DEPTH - 2);
            default:      ok = (int'(cnt) <= DEPTH - 1);
        endcase
        return ok;
    endfunction

    // Eligibility and round-robin winner selection; grants only in IDLE.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the block leaves one unassigned and no latch is inferred.
        elig0  = req0_valid && op_eligible(req0_op, occ);
        elig1  = req1_valid && op_eligible(req1_op, occ);
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !rst) begin
            if (elig0 && elig1) begin
                // Both qualify: the one that did not win last time goes now.
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                // At most one qualifies: it wins regardless of priority.
                grant0 = elig0;
                grant1 = elig1;
            end
        end
    end

    // Occupancy after the command currently on the stack interface.
    always_comb begin
        occ_issue = occ;
        case (stk_ctl)
            OP_POP:                     occ_issue = occ - OW'(1);
            OP_PUSH_BYTE, OP_PUSH_WORD: occ_issue = occ + OW'(1);
            OP_PUSH_PAIR:               occ_issue = occ + OW'(2);
            default:                    occ_issue = occ;
        endcase
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign full  = (occ == OW'(DEPTH));
    assign empty = (occ == '0);

    // During POP_WAIT the stack's registered output already holds the popped
    // word, so the owner sees it in the same cycle as its rvalid strobe; the
    // holding register captures it at the end of that cycle.
    assign req0_rdata = (state == POP_WAIT && !id_q) ? stk_dout : rdata0_q;
    assign req1_rdata = (state == POP_WAIT &&  id_q) ? stk_dout : rdata1_q;

    // Sequencer FSM with registered stack command and return strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            id_q        <= 1'b0;
            occ         <= '0;
            stk_valid   <= 1'b0;
            stk_ctl     <= OP_POP;
            stk_din     <= '0;
            req0_rvalid <= 1'b0;
            req1_rvalid <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            ovf_err     <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register here samples the values from before this edge.
            req0_rvalid <= 1'b0;
            req1_rvalid <= 1'b0;

            if (stk_wait) begin
                ovf_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        id_q       <= grant1;
                        last_grant <= grant1;
                        stk_valid  <= 1'b1;
                        stk_ctl    <= grant1 ? req1_op   : req0_op;
                        stk_din    <= grant1 ? req1_data : req0_data;
                        state      <= ISSUE;
                    end
                end

                ISSUE: begin
                    occ       <= occ_issue;
                    stk_valid <= 1'b0;
                    stk_ctl   <= OP_POP;
                    stk_din   <= '0;
                    if (stk_ctl == OP_POP) begin
                        req0_rvalid <= !id_q;
                        req1_rvalid <=  id_q;
                        state       <= POP_WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end

                POP_WAIT: begin
                    if (id_q) begin
                        rdata1_q <= stk_dout;
                    end else begin
                        rdata0_q <= stk_dout;
                    end
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Structural invariants of the sequencer.
    a_one_grant : assert property (@(posedge clk) disable iff (rst)
        !(req0_ready && req1_ready));
    a_occ_range : assert property (@(posedge clk) disable iff (rst)
        int'(occ) <= DEPTH);
    a_cmd_issue : assert property (@(posedge clk) disable iff (rst)
        stk_valid == (state == ISSUE));

endmodule

// File: tb/tb_stack_req_arbiter.sv
// Directed bench for stack_req_arbiter: a cycle table for push/pop basics,
// then hand-written sequences for fairness, eligibility skipping, underflow
// blocking, sticky overflow error and asynchronous reset during POP_WAIT.
// A small behavioural stack sits on the stk_* side.

module tb_stack_req_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [1:0]  req0_op, req1_op;
    logic [15:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        req0_rvalid, req1_rvalid;
    logic [15:0] req0_rdata, req1_rdata;
    logic        stk_valid;
    logic [1:0]  stk_ctl;
    logic [15:0] stk_din;
    logic [15:0] stk_dout;
    logic        stk_wait;
    logic [1:0]  occ;
    logic        full, empty, ovf_err;

    int checks;
    int failures;

    stack_req_arbiter #(.DEPTH(3), .DW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_op    (req0_op),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req0_rvalid(req0_rvalid),
        .req0_rdata (req0_rdata),
        .req1_valid (req1_valid),
        .req1_op    (req1_op),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .req1_rvalid(req1_rvalid),
        .req1_rdata (req1_rdata),
        .stk_valid  (stk_valid),
        .stk_ctl    (stk_ctl),
        .stk_din    (stk_din),
        .stk_dout   (stk_dout),
        .stk_wait   (stk_wait),
        .occ        (occ),
        .full       (full),
        .empty      (empty),
        .ovf_err    (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 3-entry stack: byte pushes zero-extend, a pair push stores
    // the low byte then the high byte, a pop loads the top into stk_dout.
    logic [15:0] mem [0:2];
    logic [1:0]  sp;
    logic        model_ovf;
    logic        wait_force;

    assign stk_wait = model_ovf | wait_force;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sp        <= 2'd0;
            stk_dout  <= 16'h0000;
            model_ovf <= 1'b0;
        end else begin
            model_ovf <= 1'b0;
            if (stk_valid) begin
                case (stk_ctl)
                    2'b00: if (sp != 2'd0) begin
                        stk_dout <= mem[sp - 2'd1];
                        sp       <= sp - 2'd1;
                    end
                    2'b01: if (sp <= 2'd2) begin
                        mem[sp] <= {8'h00, stk_din[7:0]};
                        sp      <= sp + 2'd1;
                    end else model_ovf <= 1'b1;
                    2'b10: if (sp <= 2'd2) begin
                        mem[sp] <= stk_din;
                        sp      <= sp + 2'd1;
                    end else model_ovf <= 1'b1;
                    default: if (sp <= 2'd1) begin
                        mem[sp]        <= {8'h00, stk_din[7:0]};
                        mem[sp + 2'd1] <= {8'h00, stk_din[15:8]};
                        sp             <= sp + 2'd2;
                    end else model_ovf <= 1'b1;
                endcase
            end
        end
    end

    typedef struct packed {
        logic        v0;
        logic [1:0]  op0;
        logic [15:0] d0;
        logic        v1;
        logic [1:0]  op1;
        logic [15:0] d1;
    } vin_t;

    typedef struct packed {
        logic        rdy0;
        logic        rdy1;
        logic        sv;
        logic [1:0]  ctl;
        logic [15:0] din;
        logic [1:0]  occ;
        logic        empty;
        logic        rv0;
        logic        rv1;
        logic [15:0] rd0;
        logic [15:0] rd1;
    } vout_t;

    typedef struct packed {
        vin_t  i;
        vout_t o;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    function automatic vin_t vi(input logic v0, input logic [1:0] op0, input logic [15:0] d0,
                                input logic v1, input logic [1:0] op1, input logic [15:0] d1);
        vin_t r;
        r = {v0, op0, d0, v1, op1, d1};
        return r;
    endfunction

    function automatic vout_t vo(input logic rdy0, input logic rdy1, input logic sv,
                                 input logic [1:0] ctl, input logic [15:0] din,
                                 input logic [1:0] o, input logic e,
                                 input logic rv0, input logic rv1,
                                 input logic [15:0] rd0, input logic [15:0] rd1);
        vout_t r;
        r = {rdy0, rdy1, sv, ctl, din, o, e, rv0, rv1, rd0, rd1};
        return r;
    endfunction

    // Every output, in a fixed order, for whole-interface comparisons.
    function automatic logic [59:0] snapshot();
        return {req0_ready, req1_ready, stk_valid, stk_ctl, stk_din, occ, full, empty,
                ovf_err, req0_rvalid, req1_rvalid, req0_rdata, req1_rdata};
    endfunction

    localparam logic [59:0] RESET_SNAP = {1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 2'd0, 1'b0,
                                          1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: no DUT response within the cycle budget", name);
    endtask

    task automatic drive(input vin_t v);
        req0_valid = v.v0;
        req0_op    = v.op0;
        req0_data  = v.d0;
        req1_valid = v.v1;
        req1_op    = v.op1;
        req1_data  = v.d1;
    endtask

    task automatic idle_inputs();
        drive(vi(0, 2'b00, 16'h0, 0, 2'b00, 16'h0));
    endtask

    // Holds rst across two falling edges; returns at a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called just after inputs were driven at a falling edge. Returns in the
    // cycle whose rising edge performs the transfer (who = winner id).
    task automatic next_grant(input string name, output int who);
        who = -1;
        for (int c = 0; c < 30; c++) begin
            #1;
            check({name, "_exclusive"}, 64'(req0_ready & req1_ready), 64'd0);
            if (req0_ready || req1_ready) begin
                who = req0_ready ? 0 : 1;
                break;
            end
            @(negedge clk);
        end
        if (who < 0) timeout(name);
    endtask

    // Waits for a pop return strobe and checks owner and data.
    task automatic wait_rvalid(input string name, input int id, input logic [15:0] expd);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (req0_rvalid || req1_rvalid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) timeout(name);
        else check(name, {req0_rvalid, req1_rvalid, (id == 0) ? req0_rdata : req1_rdata},
                   {id == 0, id == 1, expd});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        int w;
        checks     = 0;
        failures   = 0;
        rst        = 1'b0;
        wait_force = 1'b0;
        idle_inputs();

        // Reset values, observed asynchronously before the first clock edge.
        #1 rst = 1'b1;
        #1 check("reset_state", 64'(snapshot()), 64'(RESET_SNAP));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Cycle table: push word ABCD by req0, pop by req1, pop blocked at
        // occ=0 while req1 pushes a byte, then req0's waiting pop goes through.
        vecs[0]  = {vi(1, 2'b10, 16'hABCD, 0, 2'b00, 16'h0),    vo(1, 0, 0, 2'b00, 16'h0,    2'd0, 1, 0, 0, 16'h0,    16'h0)};
        vecs[1]  = {vi(0, 2'b00, 16'h0,    0, 2'b00, 16'h0),    vo(0, 0, 1, 2'b10, 16'hABCD, 2'd0, 1, 0, 0, 16'h0,    16'h0)};
        vecs[2]  = {vi(0, 2'b00, 16'h0,    1, 2'b00, 16'h0),    vo(0, 1, 0, 2'b00, 16'h0,    2'd1, 0, 0, 0, 16'h0,    16'h0)};
        vecs[3]  = {vi(0, 2'b00, 16'h0,    0, 2'b00, 16'h0),    vo(0, 0, 1, 2'b00, 16'h0,    2'd1, 0, 0, 0, 16'h0,    16'h0)};
        vecs[4]  = {vi(0, 2'b00, 16'h0,    0, 2'b00, 16'h0),    vo(0, 0, 0, 2'b00, 16'h0,    2'd0, 1, 0, 1, 16'h0,    16'hABCD)};
        vecs[5]  = {vi(0, 2'b00, 16'h0,    0, 2'b00, 16'h0),    vo(0, 0, 0, 2'b00, 16'h0,    2'd0, 1, 0, 0, 16'h0,    16'hABCD)};
        vecs[6]  = {vi(1, 2'b00, 16'h0,    1, 2'b01, 16'h1234), vo(0, 1, 0, 2'b00, 16'h0,    2'd0, 1, 0, 0, 16'h0,    16'hABCD)};
        vecs[7]  = {vi(1, 2'b00, 16'h0,    0, 2'b00, 16'h0),    vo(0, 0, 1, 2'b01, 16'h1234, 2'd0, 1, 0, 0, 16'h0,    16'hABCD)};
        vecs[8]  = {vi(1, 2'b00, 16'h0,    0, 2'b00, 16'h0),    vo(1, 0, 0, 2'b00, 16'h0,    2'd1, 0, 0, 0, 16'h0,    16'hABCD)};
        vecs[9]  = {vi(0, 2'b00, 16'h0,    0, 2'b00, 16'h0),    vo(0, 0, 1, 2'b00, 16'h0,    2'd1, 0, 0, 0, 16'h0,    16'hABCD)};
        vecs[10] = {vi(0, 2'b00, 16'h0,    0, 2'b00, 16'h0),    vo(0, 0, 0, 2'b00, 16'h0,    2'd0, 1, 1, 0, 16'h0034, 16'hABCD)};
        vecs[11] = {vi(0, 2'b00, 16'h0,    0, 2'b00, 16'h0),    vo(0, 0, 0, 2'b00, 16'h0,    2'd0, 1, 0, 0, 16'h0034, 16'hABCD)};

        for (int k = 0; k < NVEC; k++) begin
            vout_t act;
            if (k > 0) @(negedge clk);
            drive(vecs[k].i);
            #1;
            act = {req0_ready, req1_ready, stk_valid, stk_ctl, stk_din, occ, empty,
                   req0_rvalid, req1_rvalid, req0_rdata, req1_rdata};
            check($sformatf("vec%0d", k), 64'(act), 64'(vecs[k].o));
        end

        // Fairness: both hold op01 from reset; grants alternate.
        do_reset();
        drive(vi(1, 2'b01, 16'h0011, 1, 2'b01, 16'h0022));
        next_grant("fair_g0", w);
        check("fair_g0", 64'(w), 64'd0);
        @(negedge clk);
        next_grant("fair_g1", w);
        check("fair_g1", 64'(w), 64'd1);
        @(negedge clk);
        next_grant("fair_g2", w);
        check("fair_g2", 64'(w), 64'd0);
        @(negedge clk);
        @(negedge clk);
        #1 check("fair_full", {req0_ready, req1_ready, full, occ}, {1'b0, 1'b0, 1'b1, 2'd3});
        @(negedge clk);
        drive(vi(1, 2'b00, 16'h0, 1, 2'b01, 16'h0022));
        next_grant("fair_pop", w);
        check("fair_pop", 64'(w), 64'd0);
        @(negedge clk);
        drive(vi(0, 2'b00, 16'h0, 1, 2'b01, 16'h0022));
        wait_rvalid("fair_pop_data", 0, 16'h0011);
        @(negedge clk);
        drive(vi(1, 2'b01, 16'h0011, 1, 2'b01, 16'h0022));
        next_grant("fair_g3", w);
        check("fair_g3", 64'(w), 64'd1);
        @(negedge clk);
        idle_inputs();

        // Eligibility skip: at occ=2 a pair push waits, a byte push goes.
        do_reset();
        drive(vi(0, 2'b00, 16'h0, 1, 2'b10, 16'h1111));
        next_grant("elig_push_a", w);
        check("elig_push_a", 64'(w), 64'd1);
        @(negedge clk);
        drive(vi(0, 2'b00, 16'h0, 1, 2'b10, 16'h2222));
        next_grant("elig_push_b", w);
        check("elig_push_b", 64'(w), 64'd1);
        @(negedge clk);
        drive(vi(1, 2'b11, 16'hBEEF, 1, 2'b01, 16'h0033));
        next_grant("elig_skip", w);
        check("elig_skip", {64'(w), occ}, {64'd1, 2'd2});
        @(negedge clk);
        drive(vi(1, 2'b11, 16'hBEEF, 0, 2'b00, 16'h0));
        @(negedge clk);
        #1 check("elig_full", {req0_ready, occ, full}, {1'b0, 2'd3, 1'b1});
        @(negedge clk);
        drive(vi(1, 2'b11, 16'hBEEF, 1, 2'b00, 16'h0));
        next_grant("elig_pop1", w);
        check("elig_pop1", 64'(w), 64'd1);
        @(negedge clk);
        drive(vi(1, 2'b11, 16'hBEEF, 0, 2'b00, 16'h0));
        wait_rvalid("elig_pop1_data", 1, 16'h0033);
        @(negedge clk);
        #1 check("elig_wait_occ2", {req0_ready, occ}, {1'b0, 2'd2});
        drive(vi(1, 2'b11, 16'hBEEF, 1, 2'b00, 16'h0));
        next_grant("elig_pop2", w);
        check("elig_pop2", 64'(w), 64'd1);
        @(negedge clk);
        drive(vi(1, 2'b11, 16'hBEEF, 0, 2'b00, 16'h0));
        wait_rvalid("elig_pop2_data", 1, 16'h2222);
        next_grant("elig_late", w);
        check("elig_late", {64'(w), occ}, {64'd0, 2'd1});
        @(negedge clk);
        idle_inputs();
        #1 check("elig_pair_issue", {stk_valid, stk_ctl, stk_din}, {1'b1, 2'b11, 16'hBEEF});
        @(negedge clk);
        #1 check("elig_pair_occ", {occ, full, ovf_err}, {2'd3, 1'b1, 1'b0});

        // Underflow block: a pop at occ=0 never gets ready.
        do_reset();
        drive(vi(1, 2'b00, 16'h0, 0, 2'b00, 16'h0));
        for (int c = 0; c < 20; c++) begin
            #1 check($sformatf("uflow_c%0d", c), {req0_ready, stk_valid, empty}, 3'b001);
            @(negedge clk);
        end
        idle_inputs();

        // Sticky overflow error: one cycle of stk_wait.
        wait_force = 1'b1;
        @(negedge clk);
        wait_force = 1'b0;
        #1 check("ovf_set", 64'(ovf_err), 64'd1);
        repeat (3) @(negedge clk);
        #1 check("ovf_sticky", 64'(ovf_err), 64'd1);

        // Asynchronous reset in the middle of POP_WAIT.
        @(negedge clk);
        drive(vi(1, 2'b10, 16'h5A5A, 0, 2'b00, 16'h0));
        next_grant("arst_push", w);
        check("arst_push", 64'(w), 64'd0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        drive(vi(1, 2'b00, 16'h0, 0, 2'b00, 16'h0));
        next_grant("arst_pop", w);
        check("arst_pop", 64'(w), 64'd0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        #1 check("arst_pre", {req0_rvalid, req0_rdata}, {1'b1, 16'h5A5A});
        rst = 1'b1;
        #1 check("arst_outputs", 64'(snapshot()), 64'(RESET_SNAP));
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1 check($sformatf("arst_after_c%0d", c),
                     {req0_rvalid, req1_rvalid, occ, ovf_err}, {1'b0, 1'b0, 2'd0, 1'b0});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stack_req_arbiter.md
Name: stack_req_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the 3-entry stack/queue datapath, which takes a 2-bit command, a 16-bit data in and a 16-bit registered data out.
- Tracks occupancy and grants only commands that cannot overflow or underflow the stack.
- Issues one command per grant, then returns pop data to the requester that owns it.

Parameters:
- DEPTH, 3, stack entry count; occupancy width is clog2(DEPTH+1).
- DW, 16, data width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 command valid.
- req0_op  in  2  requester 0 op: 00 pop, 01 push low byte, 10 push word, 11 push two bytes (two entries).
- req0_data  in  DW  requester 0 push data.
- req0_ready  out  1  requester 0 accept; a transfer occurs on valid&&ready.
- req0_rvalid  out  1  one-cycle pop-data strobe to requester 0.
- req0_rdata  out  DW  requester 0 pop data, held until the next rvalid.
- req1_valid, req1_op, req1_data, req1_ready, req1_rvalid, req1_rdata: same as requester 0, for requester 1.
- stk_valid  out  1  command strobe to the stack; the stack acts only when this is 1.
- stk_ctl  out  2  command code (same encoding as reqN_op).
- stk_din  out  DW  stack data in.
- stk_dout  in  DW  stack registered data out.
- stk_wait  in  1  stack overflow indication.
- occ  out  clog2(DEPTH+1)  current entry count.
- full  out  1  occ==DEPTH.
- empty  out  1  occ==0.
- ovf_err  out  1  sticky; set when stk_wait=1 is sampled.

Behaviour:
- Reset values (async, take effect immediately):
  - state=IDLE, occ=0, empty=1, full=0, ovf_err=0.
  - All ready/rvalid=0, rdata=0.
  - stk_valid=0, stk_ctl=00, stk_din=0.
  - last_grant=1, so requester 0 wins first.
- Eligibility, evaluated against registered occ:
  - op00 needs occ>=1.
  - op01/10 need occ<=DEPTH-1.
  - op11 needs occ<=DEPTH-2.
  - An ineligible request is never granted. It is not dropped: it waits with ready low.
- Arbitration, in IDLE only:
  - Among valid and eligible requesters, one wins.
  - If both qualify, the one not equal to last_grant wins.
  - An eligible requester wins over an ineligible one regardless of priority.
- reqN_ready: combinational; 1 only in IDLE for the winner.
- On transfer: latch op, data and id; set last_grant=id; go to ISSUE.
- ISSUE (1 cycle):
  - stk_valid=1; stk_ctl and stk_din driven from the latches.
  - occ updates at end of cycle: -1 for op00, +1 for op01/10, +2 for op11.
  - Next state: POP_WAIT if op00, else IDLE.
- POP_WAIT (1 cycle):
  - Sample stk_dout into req<id>_rdata.
  - Pulse req<id>_rvalid for this cycle; the other requester's rvalid stays 0.
  - Next state: IDLE.
- stk_valid is 0 in IDLE and POP_WAIT; stk_ctl and stk_din return to 0 there.
- Latency, accept edge to stack command: 1 cycle.
- Latency, accept to rvalid: 2 cycles.
- Throughput: push one per 2 cycles; pop one per 3 cycles.
- Requester side:
  - Requester changes to op/data while ready=0 are legal.
  - Only the value at the transfer edge is used.
- stk_wait=1 sampled in any state sets ovf_err until rst. Correct sequencing must never set it.
- Reset mid-operation: state goes to IDLE at once. A pending pop produces no rvalid, and occ clears. The stack shares rst.
- full and empty are derived combinationally from registered occ; there is no glitch path from requester inputs.
- req0 and req1 are never granted in the same cycle.

Test Plan:
- Push word: after reset, req0 op10 data 16'hABCD.
  - req0_ready=1 same cycle.
  - Next cycle: stk_valid=1, stk_ctl=10, stk_din=ABCD.
  - Then occ=1, empty=0.
- Pop: from occ=1, req1 op00, with the stack model returning ABCD.
  - stk_ctl=00 one cycle after accept.
  - req1_rvalid=1 and req1_rdata=16'hABCD two cycles after accept.
  - req0_rvalid stays 0; occ=0.
- Fairness: both requesters hold op01 (data 0x0011 and 0x0022) from reset, with the stack popped externally between bursts.
  - Grants alternate 0,1,0,1; no ready overlap.
- Eligibility skip: at occ=2, req0 op11 and req1 op01.
  - req0_ready stays 0; req1 is granted.
  - occ=3, full=1; req0 then waits until occ<=1.
- Underflow block: at occ=0, req0 op00 held for 20 cycles.
  - ready stays 0, stk_valid stays 0, empty=1.
- Async reset during POP_WAIT:
  - All outputs reach their reset values before the next clk edge.
  - No rvalid; occ=0; ovf_err=0.
